// File: rtl/ex_stage.sv
// Execute stage: logic/shift/move ALU, HI/LO special registers and the EX/MEM
// write-back register with synchronous reset, flush and stall.
module ex_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [7:0]            alu_op_i,
  input  logic [2:0]            alu_sel_i,
  input  logic [DATA_W-1:0]     operand_1_i,
  input  logic [DATA_W-1:0]     operand_2_i,
  input  logic [REG_ADDR_W-1:0] reg_write_addr_i,
  input  logic                  reg_write_en_i,
  output logic [REG_ADDR_W-1:0] wb_addr_o,
  output logic                  wb_en_o,
  output logic [DATA_W-1:0]     wb_data_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o
);

  localparam logic [7:0] ExeAndOp  = 8'b0010_0100;
  localparam logic [7:0] ExeOrOp   = 8'b0010_0101;
  localparam logic [7:0] ExeXorOp  = 8'b0010_0110;
  localparam logic [7:0] ExeNorOp  = 8'b0010_0111;
  localparam logic [7:0] ExeSllOp  = 8'b0111_1100;
  localparam logic [7:0] ExeSrlOp  = 8'b0000_0010;
  localparam logic [7:0] ExeSraOp  = 8'b0000_0011;
  localparam logic [7:0] ExeMovzOp = 8'b0000_1010;
  localparam logic [7:0] ExeMovnOp = 8'b0000_1011;
  localparam logic [7:0] ExeMfhiOp = 8'b0001_0000;
  localparam logic [7:0] ExeMthiOp = 8'b0001_0001;
  localparam logic [7:0] ExeMfloOp = 8'b0001_0010;
  localparam logic [7:0] ExeMtloOp = 8'b0001_0011;

  localparam logic [2:0] ExeResLogic = 3'b001;
  localparam logic [2:0] ExeResShift = 3'b010;
  localparam logic [2:0] ExeResMove  = 3'b011;

  logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic                  wb_en_q, wb_en_d;
  logic [DATA_W-1:0]     wb_data_q, wb_data_d;
  logic [DATA_W-1:0]     hi_q, hi_d;
  logic [DATA_W-1:0]     lo_q, lo_d;

  logic [DATA_W-1:0] result;
  logic [4:0]        shamt;
  logic              is_mthi, is_mtlo;

  assign shamt   = operand_1_i[4:0];
  assign is_mthi = (alu_op_i == ExeMthiOp);
  assign is_mtlo = (alu_op_i == ExeMtloOp);

  always_comb begin
    result = '0;
    case (alu_sel_i)
      ExeResLogic: begin
        case (alu_op_i)
          ExeOrOp:  result = operand_1_i | operand_2_i;
          ExeAndOp: result = operand_1_i & operand_2_i;
          ExeXorOp: result = operand_1_i ^ operand_2_i;
          ExeNorOp: result = ~(operand_1_i | operand_2_i);
          default:  result = '0;
        endcase
      end
      ExeResShift: begin
        case (alu_op_i)
          ExeSllOp: result = operand_2_i << shamt;
          ExeSrlOp: result = operand_2_i >> shamt;
          ExeSraOp: result = $signed(operand_2_i) >>> shamt;
          default:  result = '0;
        endcase
      end
      ExeResMove: begin
        // MOVN/MOVZ conditions are resolved in decode via reg_write_en_i.
        case (alu_op_i)
          ExeMfhiOp:            result = hi_q;
          ExeMfloOp:            result = lo_q;
          ExeMovnOp, ExeMovzOp: result = operand_1_i;
          default:              result = '0;
        endcase
      end
      default: result = '0;
    endcase
  end

  always_comb begin
    wb_addr_d = wb_addr_q;
    wb_en_d   = wb_en_q;
    wb_data_d = wb_data_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (rst) begin
      wb_addr_d = '0;
      wb_en_d   = 1'b0;
      wb_data_d = '0;
      hi_d      = '0;
      lo_d      = '0;
    end else if (flush_i) begin
      wb_addr_d = '0;
      wb_en_d   = 1'b0;
      wb_data_d = '0;
    end else if (!stall_i) begin
      wb_addr_d = reg_write_addr_i;
      wb_en_d   = reg_write_en_i & ~(is_mthi | is_mtlo);
      wb_data_d = result;
      if (is_mthi) hi_d = operand_1_i;
      if (is_mtlo) lo_d = operand_1_i;
    end
  end

  always_ff @(posedge clk) begin
    wb_addr_q <= wb_addr_d;
    wb_en_q   <= wb_en_d;
    wb_data_q <= wb_data_d;
    hi_q      <= hi_d;
    lo_q      <= lo_d;
  end

  assign wb_addr_o = wb_addr_q;
  assign wb_en_o   = wb_en_q;
  assign wb_data_o = wb_data_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vector table followed by randomized traffic
// checked against an arithmetic reference model.
module tb_ex_stage;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_MOVZ = 8'h0A;
  localparam logic [7:0] OP_MOVN = 8'h0B;
  localparam logic [7:0] OP_MFHI = 8'h10;
  localparam logic [7:0] OP_MTHI = 8'h11;
  localparam logic [7:0] OP_MFLO = 8'h12;
  localparam logic [7:0] OP_MTLO = 8'h13;
  localparam logic [2:0] S_NOP = 3'd0, S_LOG = 3'd1, S_SHF = 3'd2, S_MOV = 3'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
  logic [7:0]  alu_op_i = '0;
  logic [2:0]  alu_sel_i = '0;
  logic [31:0] operand_1_i = '0, operand_2_i = '0;
  logic [4:0]  reg_write_addr_i = '0;
  logic        reg_write_en_i = 1'b0;
  logic [4:0]  wb_addr_o;
  logic        wb_en_o;
  logic [31:0] wb_data_o, hi_o, lo_o;

  int n_tests = 0;
  int n_fail  = 0;

  ex_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .alu_op_i         (alu_op_i),
    .alu_sel_i        (alu_sel_i),
    .operand_1_i      (operand_1_i),
    .operand_2_i      (operand_2_i),
    .reg_write_addr_i (reg_write_addr_i),
    .reg_write_en_i   (reg_write_en_i),
    .wb_addr_o        (wb_addr_o),
    .wb_en_o          (wb_en_o),
    .wb_data_o        (wb_data_o),
    .hi_o             (hi_o),
    .lo_o             (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, flush;
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] o1, o2;
    logic [4:0]  addr;
    logic        en;
    logic [4:0]  e_addr;
    logic        e_en;
    logic [31:0] e_data, e_hi, e_lo;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic s, input logic f, input logic [7:0] op,
                              input logic [2:0] sel, input logic [31:0] o1, input logic [31:0] o2,
                              input logic [4:0] a, input logic en, input logic [4:0] ea,
                              input logic een, input logic [31:0] ed, input logic [31:0] eh,
                              input logic [31:0] el);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.op = op; v.sel = sel; v.o1 = o1; v.o2 = o2;
    v.addr = a; v.en = en; v.e_addr = ea; v.e_en = een; v.e_data = ed; v.e_hi = eh; v.e_lo = el;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic r, input logic s, input logic f, input logic [7:0] op,
                       input logic [2:0] sel, input logic [31:0] o1, input logic [31:0] o2,
                       input logic [4:0] a, input logic en);
    rst = r; stall_i = s; flush_i = f; alu_op_i = op; alu_sel_i = sel;
    operand_1_i = o1; operand_2_i = o2; reg_write_addr_i = a; reg_write_en_i = en;
    @(posedge clk);
    #1;
  endtask

  // Reference model: shifts expressed as multiply/divide by a power of two.
  function automatic logic [31:0] ref_result(input logic [2:0] sel, input logic [7:0] op,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] hi, input logic [31:0] lo);
    logic [63:0] p;
    logic [63:0] prod;
    p = 64'd1 << a[4:0];
    prod = {32'd0, b} * p;
    if (sel == S_LOG) begin
      if (op == OP_OR)  return a | b;
      if (op == OP_AND) return a & b;
      if (op == OP_XOR) return (a & ~b) | (~a & b);
      if (op == OP_NOR) return ~a & ~b;
    end else if (sel == S_SHF) begin
      if (op == OP_SLL) return prod[31:0];
      if (op == OP_SRL) return b / p[31:0];
      if (op == OP_SRA) return b[31] ? ~((~b) / p[31:0]) : b / p[31:0];
    end else if (sel == S_MOV) begin
      if (op == OP_MFHI) return hi;
      if (op == OP_MFLO) return lo;
      if (op == OP_MOVN || op == OP_MOVZ) return a;
    end
    return 32'd0;
  endfunction

  logic [7:0] legal_op  [13] = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA,
                                 OP_MOVZ, OP_MOVN, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO};
  logic [2:0] legal_sel [13] = '{S_LOG, S_LOG, S_LOG, S_LOG, S_SHF, S_SHF, S_SHF,
                                 S_MOV, S_MOV, S_MOV, S_MOV, S_NOP, S_NOP};

  initial begin
    logic [4:0]  m_addr;
    logic        m_en;
    logic [31:0] m_data, m_hi, m_lo, res;

    // Directed table: inputs applied for one edge, outputs checked just after.
    vecs.push_back(mk(1,0,0, OP_OR,   S_LOG, 32'h0000_F0F0, 32'h0F0F_0000, 5, 1,
                      0, 0, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk(0,0,0, OP_OR,   S_LOG, 32'h0000_F0F0, 32'h0F0F_0000, 5, 1,
                      5, 1, 32'h0F0F_F0F0, 32'h0, 32'h0));
    vecs.push_back(mk(0,0,0, OP_NOR,  S_LOG, 32'h0000_F0F0, 32'h0F0F_0000, 5, 1,
                      5, 1, 32'hF0F0_0F0F, 32'h0, 32'h0));
    vecs.push_back(mk(0,0,0, OP_SRA,  S_SHF, 32'h4, 32'h8000_0010, 6, 1,
                      6, 1, 32'hF800_0001, 32'h0, 32'h0));
    vecs.push_back(mk(0,0,0, OP_SRL,  S_SHF, 32'h4, 32'h8000_0010, 6, 1,
                      6, 1, 32'h0800_0001, 32'h0, 32'h0));
    vecs.push_back(mk(0,0,0, OP_SLL,  S_SHF, 32'h25, 32'h1, 6, 1,
                      6, 1, 32'h0000_0020, 32'h0, 32'h0));
    vecs.push_back(mk(0,0,0, OP_MTHI, S_NOP, 32'hDEAD_BEEF, 32'h0, 0, 1,
                      0, 0, 32'h0, 32'hDEAD_BEEF, 32'h0));
    vecs.push_back(mk(0,0,0, OP_MFHI, S_MOV, 32'h0, 32'h0, 3, 1,
                      3, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0));
    vecs.push_back(mk(0,0,0, OP_AND,  S_LOG, 32'hFF00_FF00, 32'h0FF0_0FF0, 7, 1,
                      7, 1, 32'h0F00_0F00, 32'hDEAD_BEEF, 32'h0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0,1,0, OP_XOR, S_LOG, 32'hFF00_FF00, 32'h0FF0_0FF0, 8, 1,
                        7, 1, 32'h0F00_0F00, 32'hDEAD_BEEF, 32'h0));
    vecs.push_back(mk(0,0,0, OP_XOR,  S_LOG, 32'hFF00_FF00, 32'h0FF0_0FF0, 8, 1,
                      8, 1, 32'hF0F0_F0F0, 32'hDEAD_BEEF, 32'h0));
    vecs.push_back(mk(0,1,1, OP_MTLO, S_NOP, 32'h1234, 32'h0, 9, 1,
                      0, 0, 32'h0, 32'hDEAD_BEEF, 32'h0));
    vecs.push_back(mk(0,0,0, OP_MTLO, S_NOP, 32'h1234, 32'h0, 9, 1,
                      9, 0, 32'h0, 32'hDEAD_BEEF, 32'h1234));
    vecs.push_back(mk(0,0,0, OP_MFLO, S_MOV, 32'h0, 32'h0, 2, 1,
                      2, 1, 32'h1234, 32'hDEAD_BEEF, 32'h1234));
    vecs.push_back(mk(0,0,0, OP_MOVN, S_MOV, 32'hCAFE, 32'h5, 4, 0,
                      4, 0, 32'hCAFE, 32'hDEAD_BEEF, 32'h1234));
    vecs.push_back(mk(0,0,0, OP_SLL,  S_LOG, 32'hFFFF_FFFF, 32'h1, 0, 1,
                      0, 1, 32'h0, 32'hDEAD_BEEF, 32'h1234));
    vecs.push_back(mk(1,0,0, OP_OR,   S_LOG, 32'h1, 32'h2, 5, 1,
                      0, 0, 32'h0, 32'h0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].op, vecs[i].sel,
            vecs[i].o1, vecs[i].o2, vecs[i].addr, vecs[i].en);
      check($sformatf("vec%0d wb_addr", i), {27'd0, wb_addr_o}, {27'd0, vecs[i].e_addr});
      check($sformatf("vec%0d wb_en", i),   {31'd0, wb_en_o},   {31'd0, vecs[i].e_en});
      check($sformatf("vec%0d wb_data", i), wb_data_o, vecs[i].e_data);
      check($sformatf("vec%0d hi", i),      hi_o, vecs[i].e_hi);
      check($sformatf("vec%0d lo", i),      lo_o, vecs[i].e_lo);
    end

    // Randomized phase; table ended in reset so the model starts from zero.
    m_addr = '0; m_en = 1'b0; m_data = '0; m_hi = '0; m_lo = '0;
    for (int c = 0; c < 600; c++) begin
      logic        r, s, f, en;
      logic [7:0]  op;
      logic [2:0]  sel;
      logic [31:0] o1, o2;
      logic [4:0]  a;
      int          k;
      r  = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 4) == 0);
      f  = ($urandom_range(0, 7) == 0);
      k  = $urandom_range(0, 14);
      if (k < 13) begin
        op = legal_op[k]; sel = legal_sel[k];
      end else begin
        op = 8'($urandom); sel = 3'($urandom);
      end
      o1 = $urandom; o2 = $urandom;
      if ($urandom_range(0, 3) == 0) o2[31] = 1'b1;
      a  = 5'($urandom); en = 1'($urandom);

      res = ref_result(sel, op, o1, o2, m_hi, m_lo);
      if (r) begin
        m_addr = '0; m_en = 1'b0; m_data = '0; m_hi = '0; m_lo = '0;
      end else if (f) begin
        m_addr = '0; m_en = 1'b0; m_data = '0;
      end else if (!s) begin
        m_addr = a;
        m_en   = en && op != OP_MTHI && op != OP_MTLO;
        m_data = res;
        if (op == OP_MTHI) m_hi = o1;
        if (op == OP_MTLO) m_lo = o1;
      end

      apply(r, s, f, op, sel, o1, o2, a, en);
      check($sformatf("rnd%0d wb_addr", c), {27'd0, wb_addr_o}, {27'd0, m_addr});
      check($sformatf("rnd%0d wb_en", c),   {31'd0, wb_en_o},   {31'd0, m_en});
      check($sformatf("rnd%0d wb_data", c), wb_data_o, m_data);
      check($sformatf("rnd%0d hi", c),      hi_o, m_hi);
      check($sformatf("rnd%0d lo", c),      lo_o, m_lo);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
